pb_conditioner: RTL
===================

Name: pb_conditioner

Overview:
- Input-conditioning stage that sits directly upstream of the game controller. It takes the raw 20-bit push-button bus and produces clean per-button levels.
- Outputs:
  - one-cycle key strobe on each new press;
  - encoded index of the pressed key;
  - sticky mask of every key pressed since the last clear.
- The controller uses the strobe to advance and the sticky mask to judge whether a round was passed.
- Runs on the 100 Hz system clock.

Parameters:
- NBTN, 20, number of push-button inputs; code width is 5 bits for the default.
- DB_CYCLES, 3, consecutive cycles a synchronized input must differ from the debounced level before the level changes; legal range 1..15.

Ports:
- clk  input  1  system clock (hz100), all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- in  input  NBTN  raw push-button levels, asynchronous to clk, 1 = pressed.
- clr  input  1  synchronous clear of held/count (controller pulses at round start).
- stable  output  NBTN  debounced button levels.
- strobe  output  1  one-cycle pulse when at least one button's debounced level rose 0->1.
- code  output  5  index of lowest-numbered button that rose in the strobe event.
- multi  output  1  high with strobe when more than one button rose in the same cycle.
- held  output  NBTN  sticky OR of all rises since last clr/reset.
- count  output  5  popcount of held, combinational from held.

Behaviour:
- Reset (rst=0, asynchronous):
  - sync stages, stable, debounce counters, strobe, code, multi and held all clear to 0.
  - count therefore reads 0.
- Synchronizer:
  - two flops per bit, s1 <= in, s2 <= s1.
  - Only s2 is used downstream.
- Debounce, per bit independently, with a counter of 4 bits:
  - If s2 == stable: counter <= 0.
  - Else if counter == DB_CYCLES-1: stable <= s2, counter <= 0.
  - Else: counter <= counter+1.
  - Any single-cycle return to equality restarts the count, so glitches shorter than DB_CYCLES cycles never change stable.
- Rise detect:
  - rise = s2 & ~stable & (counter == DB_CYCLES-1), i.e. the bits whose stable goes 0->1 at this edge.
  - All of strobe, code, multi and held are registered from rise at the same edge as stable updates.
  - Consequence: strobe is high in the same cycle stable first shows the new 1.
- Latency, DB_CYCLES=3:
  - in rises before edge 1, s2 high after edge 2.
  - stable[i] and strobe high after edge 5.
  - strobe drops after edge 6.
  - General: stable and strobe rise 2+DB_CYCLES edges after in is sampled.
- strobe: 1 for exactly one cycle per edge on which rise != 0. Back-to-back rises on different cycles give back-to-back strobes.
- code:
  - Loaded only when rise != 0, with the lowest set index of rise.
  - Otherwise holds its previous value.
- multi:
  - Registered as (popcount(rise) > 1) when rise != 0.
  - 0 otherwise; it is a pulse aligned with strobe.
- Releases (1->0 debounced):
  - stable updates after the same delay.
  - No strobe, code, held or multi effect.
- held: held <= (clr ? 0 : held) | rise.
  - A rise coincident with clr is retained.
  - Re-pressing a bit already in held still strobes; held is unchanged.
- count: number of ones in held, range 0..NBTN.
- Reset mid-operation:
  - All state clears immediately.
  - A button still physically pressed when rst deasserts is treated as a new press: strobe fires 2+DB_CYCLES cycles later.
- Full-bus boundary: all NBTN buttons rising together gives one strobe, code=0, multi=1, held=all ones, count=20.

Decomposition:
- Shared package: NBTN default, code width constant, and a function for lowest-set-index (priority encode) plus popcount, reused by the controller's round check.
- One natural sub-module: pb_debounce_bit (synchronizer + counter + stable flop for one bit, DB_CYCLES parameter), generated NBTN times.
- Encoder, strobe and held logic stay in the parent.

Test Plan:
- Reset then press in[7] held steady, DB_CYCLES=3 -> stable[7]=1 and strobe=1 on edge 5 after press, strobe=0 on edge 6; code=7, multi=0, held=0x00080, count=1.
- in[4] high for 2 cycles then low (glitch) -> stable, strobe, held never change; code retains prior value.
- in[3] and in[12] rise in the same cycle -> single strobe, code=3, multi=1, held bits 3 and 12 set, count=2.
- Press in[0], release, then pulse clr on the same cycle that in[9]'s rise registers -> held=0x00200 (bit 9 only), count=1; release of in[0] generates no strobe.
- Hold in[19] pressed, assert rst=0 mid-operation for 2 cycles -> all outputs 0 immediately; after rst=1, strobe with code=19 exactly 5 edges later.
- Press in[2], release after debounce, press again -> two separate strobes, both code=2; held stays 0x00004, count=1.

Source files
------------

// File: rtl/pb_conditioner_pkg.sv
// Shared constants and helpers for push-button conditioning.
// The controller's round check reuses these helpers.
package pb_conditioner_pkg;

  localparam int unsigned PB_NBTN   = 20;
  localparam int unsigned PB_CODE_W = 5;

  // Lowest set index; returns 0 when the vector is empty.
  function automatic logic [PB_CODE_W-1:0] pb_prio_enc(input logic [PB_NBTN-1:0] v);
    logic [PB_CODE_W-1:0] enc;
    logic                 found;
    enc   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < PB_NBTN; i++) begin
      if (v[i] && !found) begin
        enc   = PB_CODE_W'(i);
        found = 1'b1;
      end
    end
    return enc;
  endfunction

  function automatic logic [PB_CODE_W-1:0] pb_popcount(input logic [PB_NBTN-1:0] v);
    logic [PB_CODE_W-1:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < PB_NBTN; i++) begin
      cnt = cnt + PB_CODE_W'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/pb_conditioner_debounce.sv
// One button: two-flop synchronizer, debounce counter and stable level.
// rise marks the edge on which stable will go 0->1.
module pb_debounce_bit #(
  parameter int unsigned DB_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic stable,
  output logic rise
);

  localparam logic [3:0] CNT_MAX = 4'(DB_CYCLES - 1);

  logic       s1;
  logic       s2;
  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      s1 <= in;
      s2 <= s1;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

  always_comb begin
    rise = s2 & ~stable & (cnt == CNT_MAX);
  end

endmodule

// File: rtl/pb_conditioner.sv
// Push-button conditioner: per-bit debounce, press strobe with encoded
// index, multi-press flag and a sticky held mask with its popcount.
module pb_conditioner
  import pb_conditioner_pkg::*;
#(
  parameter int unsigned NBTN      = PB_NBTN,
  parameter int unsigned DB_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NBTN-1:0]      in,
  input  logic                 clr,
  output logic [NBTN-1:0]      stable,
  output logic                 strobe,
  output logic [PB_CODE_W-1:0] code,
  output logic                 multi,
  output logic [NBTN-1:0]      held,
  output logic [PB_CODE_W-1:0] count
);

  logic [NBTN-1:0] rise;

  for (genvar g = 0; g < NBTN; g++) begin : g_bit
    pb_debounce_bit #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .clk   (clk),
      .rst   (rst),
      .in    (in[g]),
      .stable(stable[g]),
      .rise  (rise[g])
    );
  end

  // Registered from rise so strobe lines up with the first cycle stable shows 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      strobe <= 1'b0;
      code   <= '0;
      multi  <= 1'b0;
      held   <= '0;
    end else begin
      strobe <= |rise;
      multi  <= (pb_popcount(rise) > PB_CODE_W'(1));
      if (|rise) begin
        code <= pb_prio_enc(rise);
      end
      held <= (clr ? '0 : held) | rise;
    end
  end

  always_comb begin
    count = pb_popcount(held);
  end

endmodule
